// File: rtl/display_sequencer_pkg.sv
// Shared constants for the seven-segment display sequencer: state codes and default timing.
package display_sequencer_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DEF_DWELL = 12000;
    localparam int unsigned DEF_GAP   = 3000;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_HI   = 3'd1;
    localparam logic [STATE_W-1:0] S_GAP1 = 3'd2;
    localparam logic [STATE_W-1:0] S_LO   = 3'd3;
    localparam logic [STATE_W-1:0] S_GAP2 = 3'd4;

endpackage

// File: rtl/display_sequencer_dwell_timer.sv
// Per-state cycle counter: counts 0..limit, saturates there, and flags the last cycle.
module dwell_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             last_c
);

    assign last_c = (cnt == limit);

    // Clear wins over counting so a state change always starts the new state at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !last_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Captures an 8-bit value and shows it as high nibble (DP lit), gap, low nibble, gap.
module display_sequencer
    import display_sequencer_pkg::*;
#(
    parameter int unsigned DWELL  = DEF_DWELL,
    parameter int unsigned GAP    = DEF_GAP,
    parameter logic        REPEAT = 1'b1,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        dp,
    output logic        busy,
    output logic        frame_done
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   limit;
    logic               last_c;
    logic               accept;
    logic               clear;

    assign in_ready = ena && ((state_q == S_IDLE) || (state_q == S_GAP2));
    assign accept   = in_valid && in_ready;
    assign clear    = (state_d != state_q);

    always_comb begin
        limit = '0;
        case (state_q)
            S_HI, S_LO:     limit = CNT_W'(DWELL - 1);
            S_GAP1, S_GAP2: limit = CNT_W'(GAP - 1);
            default:        limit = '0;
        endcase
    end

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (ena),
        .limit  (limit),
        .cnt    (cnt),
        .last_c (last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= in_data;
            end
        end
    end

    // Next state; a new value accepted during GAP2 preempts the end-of-frame decision.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                S_IDLE: if (accept) state_d = S_HI;
                S_HI:   if (last_c) state_d = S_GAP1;
                S_GAP1: if (last_c) state_d = S_LO;
                S_LO:   if (last_c) state_d = S_GAP2;
                S_GAP2: begin
                    if (accept) begin
                        state_d = S_HI;
                    end else if (last_c) begin
                        state_d = REPEAT ? S_HI : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Display outputs follow registered state and data only.
    always_comb begin
        digit      = '0;
        blank      = 1'b1;
        dp         = 1'b0;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_GAP2) && last_c && ena && !accept;
        case (state_q)
            S_HI: begin
                digit = data_q[7:4];
                blank = 1'b0;
                dp    = 1'b1;
            end
            S_GAP1, S_GAP2: digit = data_q[3:0];
            S_LO: begin
                digit = data_q[3:0];
                blank = 1'b0;
            end
            default: digit = '0;
        endcase
    end

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench: two sequencers (looping and one-shot) against a frame-position model.
module tb_display_sequencer;
    import display_sequencer_pkg::*;

    localparam int unsigned D = 3;
    localparam int unsigned G = 2;
    localparam int unsigned F = 2 * D + 2 * G;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_data;

    logic       r_ready, r_blank, r_dp, r_busy, r_fd;
    logic [3:0] r_digit;
    logic       o_ready, o_blank, o_dp, o_busy, o_fd;
    logic [3:0] o_digit;

    always #5 clk = ~clk;

    display_sequencer #(.DWELL(D), .GAP(G), .REPEAT(1'b1), .CNT_W(16)) u_rep (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r_ready), .digit(r_digit), .blank(r_blank), .dp(r_dp),
        .busy(r_busy), .frame_done(r_fd)
    );

    display_sequencer #(.DWELL(D), .GAP(G), .REPEAT(1'b0), .CNT_W(16)) u_once (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
        .in_ready(o_ready), .digit(o_digit), .blank(o_blank), .dp(o_dp),
        .busy(o_busy), .frame_done(o_fd)
    );

    typedef struct {
        logic       ready;
        logic       fd;
        logic       busy;
        logic       blank;
        logic       dp;
        logic       dchk;
        logic [3:0] digit;
    } exp_t;

    exp_t       q_rep[$];
    exp_t       q_once[$];
    int         m_act[2];
    int         m_pos[2];
    logic [7:0] m_dat[2];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0;
            m_pos[k] = 0;
            m_dat[k] = 8'h00;
        end
    endtask

    // One cycle: apply inputs, predict this cycle's outputs, then advance the model across the edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        ena      = e;
        for (int k = 0; k < 2; k++) begin
            exp_t x;
            logic acc;
            x.busy  = (m_act[k] != 0);
            x.ready = e && (m_act[k] == 0 || m_pos[k] >= int'(2 * D + G));
            acc     = x.ready && v;
            x.fd    = e && (m_act[k] != 0) && m_pos[k] == int'(F - 1) && !acc;
            x.blank = 1'b1;
            x.dp    = 1'b0;
            x.dchk  = 1'b1;
            x.digit = 4'h0;
            if (m_act[k] != 0) begin
                if (m_pos[k] < int'(D)) begin
                    x.blank = 1'b0;
                    x.dp    = 1'b1;
                    x.digit = m_dat[k][7:4];
                end else if (m_pos[k] < int'(D + G)) begin
                    x.dchk = 1'b0;
                end else if (m_pos[k] < int'(2 * D + G)) begin
                    x.blank = 1'b0;
                    x.digit = m_dat[k][3:0];
                end else begin
                    x.dchk = 1'b0;
                end
            end
            if (k == 0) q_rep.push_back(x);
            else        q_once.push_back(x);
            if (e) begin
                if (acc) begin
                    m_act[k] = 1;
                    m_pos[k] = 0;
                    m_dat[k] = d;
                end else if (m_act[k] != 0) begin
                    if (m_pos[k] == int'(F - 1)) begin
                        m_pos[k] = 0;
                        if (k == 1) m_act[k] = 0;
                    end else begin
                        m_pos[k] = m_pos[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rep.rst_blank", int'(r_blank), 1);
        chk("rep.rst_busy",  int'(r_busy),  0);
        chk("rep.rst_dp",    int'(r_dp),    0);
        chk("rep.rst_digit", int'(r_digit), 0);
        chk("rep.rst_fd",    int'(r_fd),    0);
        chk("rep.rst_ready", int'(r_ready), int'(ena));
        chk("once.rst_blank", int'(o_blank), 1);
        chk("once.rst_busy",  int'(o_busy),  0);
        chk("once.rst_ready", int'(o_ready), int'(ena));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cmp(input string who, input exp_t x, input logic rdy, input logic fd,
                       input logic bsy, input logic blk, input logic dpo, input logic [3:0] dig);
        chk({who, ".in_ready"},   int'(rdy), int'(x.ready));
        chk({who, ".frame_done"}, int'(fd),  int'(x.fd));
        chk({who, ".busy"},       int'(bsy), int'(x.busy));
        chk({who, ".blank"},      int'(blk), int'(x.blank));
        chk({who, ".dp"},         int'(dpo), int'(x.dp));
        if (x.dchk) chk({who, ".digit"}, int'(dig), int'(x.digit));
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q_rep.size() > 0 && q_once.size() > 0) begin
                exp_t xr;
                exp_t xo;
                xr = q_rep.pop_front();
                xo = q_once.pop_front();
                cmp("rep",  xr, r_ready, r_fd, r_busy, r_blank, r_dp, r_digit);
                cmp("once", xo, o_ready, o_fd, o_busy, o_blank, o_dp, o_digit);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        #12 chk_reset_outputs();
        #11 rst_n = 1'b1;

        // Single frame of A5, then idle long enough for the one-shot to return to IDLE.
        drive(1'b1, 8'hA5, 1'b1);
        repeat (12) drive(1'b0, 8'h00, 1'b1);

        // Offer during GAP1 (ignored), then during GAP2 (accepted).
        drive(1'b1, 8'h3C, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h7E, 1'b1);
        repeat (4) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h7E, 1'b1);
        repeat (25) drive(1'b0, 8'h00, 1'b1);

        // Back-to-back accept on the final GAP2 cycle.
        drive(1'b1, 8'h3C, 1'b1);
        repeat (9) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h7E, 1'b1);
        repeat (12) drive(1'b0, 8'h00, 1'b1);

        // Freeze with ena=0 mid-HI while offering data that must be ignored.
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        repeat (4) drive(1'b1, 8'h99, 1'b0);
        repeat (15) drive(1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of LO.
        drive(1'b1, 8'hA5, 1'b1);
        repeat (6) drive(1'b0, 8'h00, 1'b1);
        async_reset();
        repeat (3) drive(1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional freezes and resets.
        for (int i = 0; i < 2500; i++) begin
            logic       v;
            logic       e;
            logic [7:0] d;
            v = ($urandom_range(0, 6) == 0);
            e = ($urandom_range(0, 9) != 0);
            d = 8'($urandom);
            drive(v, d, e);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        repeat (2) drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        #4;
        chk("scoreboard.drained", q_rep.size() + q_once.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
